// File: rtl/fifo_axis_packetizer.sv
// Drains a show-ahead FIFO into a registered AXI4-Stream master and marks tlast every PKT_LEN beats.
// Build macro PKTZ_PAD_TIMEOUT_EN adds zero padding of a starved packet after TIMEOUT cycles plus pad_count.
module fifo_axis_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  pkt_count,
`ifdef PKTZ_PAD_TIMEOUT_EN
    output logic [CNT_WIDTH-1:0]  pad_count,
`endif
    output logic                  busy
);

    localparam int BEAT_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    if (PKT_LEN < 2 || PKT_LEN > 65535 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_axis_packetizer: PKT_LEN must be 2..65535 and TIMEOUT at least 1");
    end

`ifdef PKTZ_PAD_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_PAD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1} state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BEAT_W-1:0]       r_beat;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic [CNT_WIDTH-1:0]    r_pkt_count;
    logic                    w_free;
    logic                    w_pop;
    logic                    w_pad_load;
    logic                    w_load;
    logic                    w_last;

    // The output register can take a new beat when empty or being drained this cycle.
    assign w_free     = !r_tvalid || m_axis_tready;
    assign w_pop      = (r_state == ST_STREAM) && w_free && !fifo_empty;
    assign w_load     = w_pop || w_pad_load;
    assign w_last     = (r_beat == LAST_BEAT);

    assign fifo_rd_en    = w_pop;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign pkt_count     = r_pkt_count;
    assign busy          = (r_state != ST_IDLE);

`ifdef PKTZ_PAD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    logic [TMO_W-1:0]     r_tmo;
    logic [CNT_WIDTH-1:0] r_pad_count;
    logic                 w_starve;
    logic                 w_timeout;

    // Starvation only counts once a packet has begun, so an idle empty FIFO never pads.
    assign w_starve   = (r_state == ST_STREAM) && (r_beat != '0) && fifo_empty;
    assign w_timeout  = w_starve && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_pad_load = (r_state == ST_PAD) && w_free;
    assign pad_count  = r_pad_count;

    // Starvation timer and padded-packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo       <= '0;
            r_pad_count <= '0;
        end else begin
            if (w_starve) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
            if (w_pad_load && w_last) begin
                r_pad_count <= r_pad_count + 1'b1;
            end
        end
    end
`else
    assign w_pad_load = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; enable is only consulted when starting a packet.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (w_pop && w_last) begin
                    w_state_nxt = ST_IDLE;
`ifdef PKTZ_PAD_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_state_nxt = ST_PAD;
`endif
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
`ifdef PKTZ_PAD_TIMEOUT_EN
            ST_PAD: begin
                if (w_pad_load && w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PAD;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output stage and beat position; a stalled beat holds until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_beat   <= '0;
        end else if (w_load) begin
            r_tdata  <= w_pop ? fifo_dout : '0;
            r_tvalid <= 1'b1;
            r_tlast  <= w_last;
            r_beat   <= w_last ? '0 : r_beat + 1'b1;
        end else if (w_free) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end
    end

    // Completed-packet counter, stepped on the handshake of each tlast beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= '0;
        end else if (r_tvalid && m_axis_tready && r_tlast) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Self-checking bench for fifo_axis_packetizer: queue-based FIFO model and a beat-index stream model.
module tb_fifo_axis_packetizer;
    localparam int DW  = 32;
    localparam int PL  = 4;
    localparam int CW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [CW-1:0] pkt_count;
`ifdef PKTZ_PAD_TIMEOUT_EN
    logic [CW-1:0] pad_count;
`endif
    logic          busy;

    always #5 clk = ~clk;

    fifo_axis_packetizer #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .pkt_count(pkt_count),
`ifdef PKTZ_PAD_TIMEOUT_EN
        .pad_count(pad_count),
`endif
        .busy(busy)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend[$];
    int            hs_cyc[$];
    int            n_out, n_pop, cyc;
    logic          pop_seen, prev_stall, prev_last, feed_random;
    logic [DW-1:0] prev_data;

    // One clock: sample outputs at negedge, then let the FIFO model react after the posedge.
    task automatic step();
        logic [DW-1:0] exp_d;
        logic          exp_l;
        @(negedge clk);
        pop_seen = 1'b0;
        if (rst_n) begin
            pop_seen = fifo_rd_en;
            if (fifo_rd_en) begin
                checks++;
                if (fifo_empty) begin
                    errors++;
                    $display("FAIL rd_en_when_empty: rd_en=1 with fifo_empty=1");
                end
            end
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got d=%h l=%b, need no beat", m_axis_tdata, m_axis_tlast);
                end else begin
                    exp_d = exp_q.pop_front();
                    exp_l = ((n_out % PL) == PL - 1);
                    if (m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
                        errors++;
                        $display("FAIL beat%0d: got d=%h l=%b, need d=%h l=%b",
                                 n_out, m_axis_tdata, m_axis_tlast, exp_d, exp_l);
                    end
                end
                n_out++;
                hs_cyc.push_back(cyc);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (pop_seen && fq.size() > 0) begin
            void'(fq.pop_front());
            n_pop++;
        end
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic feed();
        while (pend.size() > 0 && (!feed_random || $urandom_range(0, 1) == 1)) begin
            fq.push_back(pend[0]);
            exp_q.push_back(pend.pop_front());
            if (feed_random) break;
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input int mode, input string name);
        int k = 0;
        while (n_out < n && k < budget) begin
            case (mode)
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = ($urandom_range(0, 9) < 7);
                default: m_axis_tready = 1'b1;
            endcase
            feed();
            step();
            k++;
        end
        checks++;
        if (n_out < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats, need %0d", name, n_out, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; m_axis_tready = 1'b0; feed_random = 1'b0;
        fq.delete(); exp_q.delete(); pend.delete(); hs_cyc.delete();
        n_out = 0; n_pop = 0; prev_stall = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic chk(input string name, input longint got, input longint need);
        checks++;
        if (got != need) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, fifo_rd_en} !== 4'b0000 || m_axis_tdata !== '0 || pkt_count !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b l=%b busy=%b rd=%b d=%h cnt=%0d, need all 0",
                     m_axis_tvalid, m_axis_tlast, busy, fifo_rd_en, m_axis_tdata, pkt_count);
        end
    endtask

    task automatic test_back_to_back(input int mode, input string name);
        do_reset();
        for (int i = 0; i < 8; i++) pend.push_back(DW'(32'h10 + i));
        enable = 1'b1;
        wait_beats(8, 120, mode, name);
        m_axis_tready = 1'b1;
        step(); step();
        chk({name, "_pkt_count"}, pkt_count, 2);
        chk({name, "_pops"}, n_pop, 8);
        if (mode == 0 && hs_cyc.size() >= 8) begin
            chk({name, "_pkt0_span"}, hs_cyc[3] - hs_cyc[0], 3);
            chk({name, "_pkt1_span"}, hs_cyc[7] - hs_cyc[4], 3);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        for (int i = 0; i < 6; i++) pend.push_back(DW'(32'h40 + i));
        enable = 1'b1;
        wait_beats(2, 50, 0, "endrop_a");
        enable = 1'b0;
        wait_beats(4, 50, 0, "endrop_b");
        for (int i = 0; i < 10; i++) step();
        chk("endrop_beats", n_out, 4);
        chk("endrop_left", fq.size(), 2);
        chk("endrop_busy", busy, 0);
        chk("endrop_pkt_count", pkt_count, 1);
    endtask

`ifndef PKTZ_PAD_TIMEOUT_EN
    task automatic test_starve();
        int hi = 0;
        do_reset();
        pend.push_back(32'hC0); pend.push_back(32'hC1);
        enable = 1'b1;
        wait_beats(2, 50, 0, "starve_a");
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_axis_tvalid) hi++;
        end
        chk("starve_tvalid_high", hi, 0);
        chk("starve_busy", busy, 1);
        pend.push_back(32'hC2); pend.push_back(32'hC3);
        wait_beats(4, 50, 0, "starve_b");
        step();
        chk("starve_pkt_count", pkt_count, 1);
    endtask
`else
    task automatic test_pad();
        do_reset();
        pend.push_back(32'hAA);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        enable = 1'b1;
        m_axis_tready = 1'b1;
        fq.push_back(pend.pop_front());
        exp_q.push_front(32'hAA);
        wait_beats(4, 60, 0, "pad");
        step();
        chk("pad_count", pad_count, 1);
        chk("pad_pops", n_pop, 1);
        chk("pad_pkt_count", pkt_count, 1);
        if (hs_cyc.size() >= 2) begin
            checks++;
            if (hs_cyc[1] - hs_cyc[0] < TMO || hs_cyc[1] - hs_cyc[0] > TMO + 2) begin
                errors++;
                $display("FAIL pad_delay: got %0d cycles, need %0d..%0d", hs_cyc[1] - hs_cyc[0], TMO, TMO + 2);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) pend.push_back(DW'(32'h70 + i));
        enable = 1'b1;
        wait_beats(5, 60, 0, "rstmid_a");
        m_axis_tready = 1'b0;
        step(); step();
        chk("rstmid_pre_tvalid", m_axis_tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_tvalid", m_axis_tvalid, 0);
        chk("rstmid_tlast", m_axis_tlast, 0);
        chk("rstmid_pkt_count", pkt_count, 0);
        do_reset();
        for (int i = 0; i < 4; i++) pend.push_back(DW'(32'h90 + i));
        enable = 1'b1;
        wait_beats(4, 60, 0, "rstmid_b");
        step();
        chk("rstmid_post_pkt_count", pkt_count, 1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int k = $urandom_range(1, 3);
            do_reset();
            for (int i = 0; i < k * PL; i++) pend.push_back(DW'($urandom));
            feed_random = 1'b1;
            enable = 1'b1;
            wait_beats(k * PL, 400, 2, "random");
            m_axis_tready = 1'b1;
            step(); step();
            chk("random_pkt_count", pkt_count, k);
            chk("random_pops", n_pop, k * PL);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; m_axis_tready = 1'b0; cyc = 0; pop_seen = 1'b0;
        test_reset();
        test_back_to_back(0, "b2b");
        test_back_to_back(1, "stall");
        test_enable_drop();
`ifndef PKTZ_PAD_TIMEOUT_EN
        test_starve();
`else
        test_pad();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
